// File: rtl/pingpong_counter_param.sv
// Ping-pong / wrap-around counter with runtime bounds, step and mode.
// Optional saturating boundary-event counter enabled by defining PPC_BOUNCE_CNT_EN.
module pingpong_counter_param #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flip,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [STEP_W-1:0] step,
    input  logic              mode,
    output logic [WIDTH-1:0]  out,
    output logic              dir,
    output logic              at_max,
    output logic              at_min,
    output logic              cfg_err
`ifdef PPC_BOUNCE_CNT_EN
    ,
    output logic [BCNT_W-1:0] bounce_cnt
`endif
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             d;
    logic [WIDTH:0]   out_x, lo_x, hi_x, step_x;
    logic [WIDTH:0]   sum_up, lo_plus, diff_dn;
    logic             hit;
    logic [WIDTH-1:0] load_clamped;

    // Sums carry one extra bit so out+step and lo+step never wrap silently.
    assign out_x   = {1'b0, out_q};
    assign lo_x    = {1'b0, lo};
    assign hi_x    = {1'b0, hi};
    assign step_x  = (WIDTH+1)'(step);
    assign sum_up  = out_x + step_x;
    assign lo_plus = lo_x + step_x;
    assign diff_dn = out_x - step_x;

    assign d       = dir_q ^ flip;
    assign cfg_err = (lo >= hi);
    assign at_max  = (out_q == hi);
    assign at_min  = (out_q == lo);
    assign out     = out_q;
    assign dir     = dir_q;

    assign hit = mode ? (d ? (out_x < lo_plus)  : (sum_up > hi_x))
                      : (d ? (out_x <= lo_plus) : (sum_up >= hi_x));

    assign load_clamped = (load_val < lo) ? lo : ((load_val > hi) ? hi : load_val);

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (load) begin
            out_d = cfg_err ? load_val : load_clamped;
        end else if (!cfg_err && !hold) begin
            if (out_q < lo) begin
                out_d = lo;
            end else if (out_q > hi) begin
                out_d = hi;
            end else if (step == '0) begin
                dir_d = d;
            end else if (!mode) begin
                if (hit) begin
                    out_d = d ? lo : hi;
                    dir_d = ~d;
                end else begin
                    out_d = d ? diff_dn[WIDTH-1:0] : sum_up[WIDTH-1:0];
                    dir_d = d;
                end
            end else begin
                if (hit) begin
                    out_d = d ? hi : lo;
                end else begin
                    out_d = d ? diff_dn[WIDTH-1:0] : sum_up[WIDTH-1:0];
                end
                dir_d = d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            dir_q <= 1'b0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end

`ifdef PPC_BOUNCE_CNT_EN
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              count_en;

    // An event is only possible on a real counting step inside the range.
    assign count_en = !load && !cfg_err && !hold && (out_q >= lo) && (out_q <= hi)
                      && (step != '0);

    always_comb begin
        bcnt_d = bcnt_q;
        if (load) begin
            bcnt_d = '0;
        end else if (count_en && hit && (bcnt_q != '1)) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign bounce_cnt = bcnt_q;
`endif

endmodule

// File: tb/tb_pingpong_counter_param.sv
// Table-driven bench for pingpong_counter_param with an expected-value queue.
module tb_pingpong_counter_param;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
    localparam int BCNT_W = 16;

    logic              clk;
    logic              rst;
    logic              hold, flip, load, mode;
    logic [WIDTH-1:0]  load_val, lo, hi;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  out;
    logic              dir, at_max, at_min, cfg_err;
`ifdef PPC_BOUNCE_CNT_EN
    logic [BCNT_W-1:0] bounce_cnt;
`endif

    pingpong_counter_param #(.WIDTH(WIDTH), .STEP_W(STEP_W), .BCNT_W(BCNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .flip     (flip),
        .load     (load),
        .load_val (load_val),
        .lo       (lo),
        .hi       (hi),
        .step     (step),
        .mode     (mode),
        .out      (out),
        .dir      (dir),
        .at_max   (at_max),
        .at_min   (at_min),
        .cfg_err  (cfg_err)
`ifdef PPC_BOUNCE_CNT_EN
        ,
        .bounce_cnt (bounce_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       hold, flip, load;
        logic [7:0] load_val, lo, hi;
        logic [3:0] step;
        logic       mode;
        logic [7:0] e_out;
        logic       e_dir;
        logic [15:0] e_bcnt;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] out, lo, hi;
        logic       dir;
        logic [15:0] bcnt;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[37];
    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(logic h, logic f, logic l, logic [7:0] lv, logic [7:0] vlo,
                                logic [7:0] vhi, logic [3:0] st, logic md,
                                logic [7:0] eo, logic ed, logic [15:0] eb);
        vec_t v;
        v.hold = h; v.flip = f; v.load = l; v.load_val = lv; v.lo = vlo; v.hi = vhi;
        v.step = st; v.mode = md; v.e_out = eo; v.e_dir = ed; v.e_bcnt = eb;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_now(exp_t e);
        chk({e.name, ".out"},     32'(out),     32'(e.out));
        chk({e.name, ".dir"},     32'(dir),     32'(e.dir));
        chk({e.name, ".at_max"},  32'(at_max),  32'(e.out == e.hi));
        chk({e.name, ".at_min"},  32'(at_min),  32'(e.out == e.lo));
        chk({e.name, ".cfg_err"}, 32'(cfg_err), 32'(e.lo >= e.hi));
`ifdef PPC_BOUNCE_CNT_EN
        chk({e.name, ".bcnt"},    32'(bounce_cnt), 32'(e.bcnt));
`endif
        $display("txn %s out=%0d dir=%0d max=%0d min=%0d err=%0d", e.name, out, dir,
                 at_max, at_min, cfg_err);
    endtask

    task automatic run_vec(string name, vec_t v);
        exp_t e;
        hold = v.hold; flip = v.flip; load = v.load; load_val = v.load_val;
        lo = v.lo; hi = v.hi; step = v.step; mode = v.mode;
        e.name = name; e.out = v.e_out; e.dir = v.e_dir; e.bcnt = v.e_bcnt;
        e.lo = v.lo; e.hi = v.hi;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check_now(sb_q.pop_front());
        end
    endtask

    initial begin
        exp_t e;
        // Bounce lo=2 hi=10 step=3 (first vector recovers out=1 up to lo)
        vecs[0]  = mk(0,0,0,  0, 2,10,3,0,  2,0,2);
        vecs[1]  = mk(0,0,0,  0, 2,10,3,0,  5,0,2);
        vecs[2]  = mk(0,0,0,  0, 2,10,3,0,  8,0,2);
        vecs[3]  = mk(0,0,0,  0, 2,10,3,0, 10,1,3);
        vecs[4]  = mk(0,0,0,  0, 2,10,3,0,  7,1,3);
        vecs[5]  = mk(0,0,0,  0, 2,10,3,0,  4,1,3);
        vecs[6]  = mk(0,0,0,  0, 2,10,3,0,  2,0,4);
        vecs[7]  = mk(0,0,0,  0, 2,10,3,0,  5,0,4);
        // Wrap lo=4 hi=9 step=2
        vecs[8]  = mk(0,0,1,  4, 4, 9,2,1,  4,0,0);
        vecs[9]  = mk(0,0,0,  0, 4, 9,2,1,  6,0,0);
        vecs[10] = mk(0,0,0,  0, 4, 9,2,1,  8,0,0);
        vecs[11] = mk(0,0,0,  0, 4, 9,2,1,  4,0,1);
        vecs[12] = mk(0,0,0,  0, 4, 9,2,1,  6,0,1);
        vecs[13] = mk(0,1,0,  0, 4, 9,2,1,  4,1,1);
        vecs[14] = mk(0,0,0,  0, 4, 9,2,1,  9,1,2);
        vecs[15] = mk(0,0,0,  0, 4, 9,2,1,  7,1,2);
        vecs[16] = mk(0,1,0,  0, 4, 9,2,1,  9,0,2);
        // Flip, hold, step=0
        vecs[17] = mk(0,0,1,  8, 0,31,1,0,  8,0,0);
        vecs[18] = mk(0,1,0,  0, 0,31,1,0,  7,1,0);
        vecs[19] = mk(1,1,0,  0, 0,31,1,0,  7,1,0);
        vecs[20] = mk(1,1,0,  0, 0,31,1,0,  7,1,0);
        vecs[21] = mk(1,1,0,  0, 0,31,1,0,  7,1,0);
        vecs[22] = mk(0,0,0,  0, 0,31,1,0,  6,1,0);
        vecs[23] = mk(0,1,0,  0, 0,31,0,0,  6,0,0);
        vecs[24] = mk(0,0,0,  0, 0,31,0,0,  6,0,0);
        // Config error, loads, range recovery from above, bounce at lo
        vecs[25] = mk(0,0,0,  0, 9, 3,1,0,  6,0,0);
        vecs[26] = mk(0,1,0,  0, 9, 3,1,0,  6,0,0);
        vecs[27] = mk(0,0,0,  0, 6, 6,1,0,  6,0,0);
        vecs[28] = mk(0,0,1, 40, 9, 3,1,0, 40,0,0);
        vecs[29] = mk(0,0,1, 40, 0,31,1,0, 31,0,0);
        vecs[30] = mk(0,0,0,  0, 0,20,1,0, 20,0,0);
        vecs[31] = mk(0,0,0,  0, 0,20,1,0, 20,1,1);
        vecs[32] = mk(0,0,0,  0, 0,20,1,0, 19,1,1);
        vecs[33] = mk(1,0,1,  1, 3,20,1,0,  3,1,0);
        vecs[34] = mk(0,0,0,  0, 3,20,5,0,  3,0,1);
        vecs[35] = mk(0,0,0,  0, 3,20,5,0,  8,0,1);
        vecs[36] = mk(0,0,0,  0, 0,31,1,0,  9,0,1);

        rst = 1'b1; hold = 0; flip = 0; load = 0; load_val = 0;
        lo = 0; hi = 31; step = 1; mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        e.name = "reset"; e.out = 0; e.dir = 0; e.bcnt = 0; e.lo = 0; e.hi = 31;
        check_now(e);
        rst = 1'b0;

        // Full bounce sweep 0..31..0..1 with step 1
        for (int i = 1; i <= 31; i++)
            run_vec($sformatf("up%0d", i),
                    mk(0,0,0,0,0,31,1,0, 8'(i), (i == 31), (i == 31) ? 16'd1 : 16'd0));
        for (int i = 1; i <= 31; i++)
            run_vec($sformatf("dn%0d", i),
                    mk(0,0,0,0,0,31,1,0, 8'(31 - i), (i != 31), (i == 31) ? 16'd2 : 16'd1));
        run_vec("up_again", mk(0,0,0,0,0,31,1,0, 1,0,2));

        for (int i = 0; i < 37; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        e.name = "async_rst"; e.out = 0; e.dir = 0; e.bcnt = 0; e.lo = 0; e.hi = 31;
        check_now(e);
        #1 rst = 1'b0;
        run_vec("resume1", mk(0,0,0,0,0,31,1,0, 1,0,0));
        run_vec("resume2", mk(0,0,0,0,0,31,1,0, 2,0,0));

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
